// File: rtl/tx_byte_serialiser_pkg.sv
// Shared Tx byte/bit stream definitions: byte width, serialiser states and
// the data_bits -> bit count mapping (0 encodes a full byte).
package tx_pkg;

    localparam int TX_BYTE_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_ser_state_t;

    function automatic logic [3:0] bits_to_count(input logic [2:0] bits);
        return (bits == 3'd0) ? 4'd8 : {1'b0, bits};
    endfunction

endpackage

// File: rtl/tx_byte_serialiser_if.sv
// Tx stream bundle shared by the byte side (BY_BYTE=1, 8-bit data) and the
// bit side (BY_BYTE=0, 1-bit data); the sink answers with a one-tick req pulse.
interface tx_interface
    import tx_pkg::*;
#(
    parameter bit BY_BYTE = 1'b1
) ();

    localparam int DW = BY_BYTE ? TX_BYTE_WIDTH : 1;

    logic [DW-1:0] data;
    logic          data_valid;
    logic [2:0]    data_bits;
    logic          last_bit_in_byte;
    logic          req;

    modport master (
        output data,
        output data_valid,
        output data_bits,
        output last_bit_in_byte,
        input  req
    );

    modport slave (
        input  data,
        input  data_valid,
        input  data_bits,
        input  last_bit_in_byte,
        output req
    );

endinterface

// File: rtl/tx_byte_serialiser.sv
// Byte-to-bit Tx serialiser, LSB- or MSB-first, partial final bytes; first bit 1 clk after valid.
// Each bit is held until downstream pulses req; upstream is asked for its next byte via in_req on each load.
module tx_byte_serialiser
    import tx_pkg::*;
#(
    parameter bit LSB_FIRST   = 1'b1,
    parameter bit USE_ASSERTS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    tx_interface.slave  in_byte,
    tx_interface.master out_bit
);

    tx_ser_state_t state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          in_req_q, in_req_d;
    logic          out_vld_q, out_vld_d;
    logic          out_dat_q, out_dat_d;
    logic          out_last_q, out_last_d;

    logic [3:0]    load_cnt;
    logic [7:0]    load_val;
    logic          advance;
    logic          load;

    always_comb begin
        load_cnt = bits_to_count(in_byte.data_bits);
        // MSB-first keeps the low n bits but aligns bit (n-1) to the MSB tap.
        load_val = LSB_FIRST ? in_byte.data : (in_byte.data << (4'd8 - load_cnt));
        advance  = (state_q == SEND) && out_bit.req;
        load     = in_byte.data_valid &&
                   ((state_q == IDLE) || (advance && (cnt_q == 4'd1)));

        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        in_req_d = 1'b0;

        if (load) begin
            state_d  = SEND;
            shreg_d  = load_val;
            cnt_d    = load_cnt;
            in_req_d = 1'b1;
        end else if (advance) begin
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                shreg_d = LSB_FIRST ? {1'b0, shreg_q[7:1]} : {shreg_q[6:0], 1'b0};
                cnt_d   = cnt_q - 4'd1;
            end
        end

        out_vld_d  = (state_d == SEND);
        out_dat_d  = LSB_FIRST ? shreg_d[0] : shreg_d[7];
        out_last_d = (state_d == SEND) && (cnt_d == 4'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            in_req_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            in_req_q   <= in_req_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
        end
    end

    assign in_byte.req              = in_req_q;
    assign out_bit.data             = out_dat_q;
    assign out_bit.data_valid       = out_vld_q;
    assign out_bit.last_bit_in_byte = out_last_q;
    assign out_bit.data_bits        = 3'd0;

    logic unused_in_last;
    assign unused_in_last = in_byte.last_bit_in_byte;

    generate
        if (USE_ASSERTS) begin : g_asserts
            logic [2:0] gap_q, gap_d;

            // Ticks since the last in_req pulse, saturating.
            always_comb begin
                gap_d = in_req_q ? 3'd0 : ((gap_q == 3'd7) ? gap_q : gap_q + 3'd1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) gap_q <= 3'd7;
                else        gap_q <= gap_d;
            end

            a_in_req_single: assert property (@(posedge clk) disable iff (!rst_n)
                in_req_q |=> !in_req_q);

            a_req_spacing: assert property (@(posedge clk) disable iff (!rst_n)
                (out_bit.req && (state_q == SEND)) |-> (!in_req_q && (gap_q >= 3'd4)));
        end
    endgenerate

endmodule

// File: tb/tb_tx_byte_serialiser.sv
// Drives an LSB-first and an MSB-first serialiser in lockstep and scoreboards both bit streams.
`timescale 1ns/1ps
module tb_tx_byte_serialiser;
    import tx_pkg::*;

    localparam int BIT_T = 128;

    typedef struct packed { logic d; logic last; } bit_exp_t;
    typedef struct packed { logic [7:0] data; logic [2:0] bits; } byte_t;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic [7:0] tb_data    = 8'h00;
    logic       tb_valid   = 1'b0;
    logic [2:0] tb_bits    = 3'd0;
    logic       tb_out_req = 1'b0;

    always #5 clk = ~clk;

    tx_interface #(.BY_BYTE(1'b1)) in_l ();
    tx_interface #(.BY_BYTE(1'b1)) in_m ();
    tx_interface #(.BY_BYTE(1'b0)) out_l ();
    tx_interface #(.BY_BYTE(1'b0)) out_m ();

    assign in_l.data             = tb_data;
    assign in_l.data_valid       = tb_valid;
    assign in_l.data_bits        = tb_bits;
    assign in_l.last_bit_in_byte = 1'b0;
    assign in_m.data             = tb_data;
    assign in_m.data_valid       = tb_valid;
    assign in_m.data_bits        = tb_bits;
    assign in_m.last_bit_in_byte = 1'b0;
    assign out_l.req             = tb_out_req;
    assign out_m.req             = tb_out_req;

    tx_byte_serialiser #(.LSB_FIRST(1'b1), .USE_ASSERTS(1'b1)) dut_l (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_byte (in_l),
        .out_bit (out_l)
    );

    tx_byte_serialiser #(.LSB_FIRST(1'b0), .USE_ASSERTS(1'b1)) dut_m (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_byte (in_m),
        .out_bit (out_m)
    );

    bit_exp_t exp_l[$];
    bit_exp_t exp_m[$];
    byte_t    src_q[$];

    int n_tests    = 0;
    int n_fail     = 0;
    int in_req_cnt = 0;
    int loads_exp  = 0;

    logic [2:0] prev_l      = 3'd0;
    logic [2:0] prev_m      = 3'd0;
    logic       prev_vld_l  = 1'b0;
    logic       prev_vld_m  = 1'b0;
    logic       prev_in_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        if (src_q.size() > 0) begin
            tb_valid = 1'b1;
            tb_data  = src_q[0].data;
            tb_bits  = src_q[0].bits;
        end else begin
            tb_valid = 1'b0;
            tb_data  = 8'($urandom);
            tb_bits  = 3'($urandom);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] b);
        byte_t    e;
        bit_exp_t x;
        int       n;
        n = (b == 3'd0) ? 8 : int'(b);
        e.data = d;
        e.bits = b;
        src_q.push_back(e);
        loads_exp++;
        for (int i = 0; i < n; i++) begin
            x.d    = d[i];
            x.last = (i == n - 1);
            exp_l.push_back(x);
            x.d    = d[n - 1 - i];
            exp_m.push_back(x);
        end
        drive_src();
    endtask

    // One clock; upstream bookkeeping and stream-wide protocol checks.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            prev_vld_l  = 1'b0;
            prev_vld_m  = 1'b0;
            prev_in_req = 1'b0;
            tb_out_req  = 1'b0;
            return;
        end
        if (in_l.req || in_m.req) begin
            chk("in_req_match", 32'(in_m.req), 32'(in_l.req));
            chk("in_req_b2b", 32'(prev_in_req), 32'd0);
            chk("in_req_has_src", 32'(src_q.size() > 0), 32'd1);
            in_req_cnt++;
            if (src_q.size() > 0) void'(src_q.pop_front());
            drive_src();
        end
        if (prev_vld_l && !tb_out_req)
            chk("stable_lsb", 32'({out_l.data_valid, out_l.data, out_l.last_bit_in_byte}), 32'(prev_l));
        if (prev_vld_m && !tb_out_req)
            chk("stable_msb", 32'({out_m.data_valid, out_m.data, out_m.last_bit_in_byte}), 32'(prev_m));
        prev_l      = {out_l.data_valid, out_l.data, out_l.last_bit_in_byte};
        prev_m      = {out_m.data_valid, out_m.data, out_m.last_bit_in_byte};
        prev_vld_l  = out_l.data_valid;
        prev_vld_m  = out_m.data_valid;
        prev_in_req = in_l.req;
        tb_out_req  = 1'b0;
    endtask

    task automatic consume_bit(input string tag);
        bit_exp_t el, em;
        chk({tag, "_vld_l"}, 32'(out_l.data_valid), 32'd1);
        chk({tag, "_vld_m"}, 32'(out_m.data_valid), 32'd1);
        chk({tag, "_pending"}, 32'(exp_l.size() > 0 && exp_m.size() > 0), 32'd1);
        if (exp_l.size() > 0 && exp_m.size() > 0) begin
            el = exp_l.pop_front();
            em = exp_m.pop_front();
            chk({tag, "_bit_l"},  32'(out_l.data), 32'(el.d));
            chk({tag, "_last_l"}, 32'(out_l.last_bit_in_byte), 32'(el.last));
            chk({tag, "_bit_m"},  32'(out_m.data), 32'(em.d));
            chk({tag, "_last_m"}, 32'(out_m.last_bit_in_byte), 32'(em.last));
        end
        tb_out_req = 1'b1;
        tick();
        chk({tag, "_vld_next_l"}, 32'(out_l.data_valid), 32'(exp_l.size() > 0));
        chk({tag, "_vld_next_m"}, 32'(out_m.data_valid), 32'(exp_m.size() > 0));
        repeat (BIT_T - 1) tick();
    endtask

    task automatic run_stream(input string tag);
        int guard;
        guard = 0;
        tick();
        chk({tag, "_lat_l"}, 32'(out_l.data_valid), 32'd1);
        chk({tag, "_lat_m"}, 32'(out_m.data_valid), 32'd1);
        repeat (8) tick();
        while (exp_l.size() > 0 && guard < 64) begin
            consume_bit(tag);
            guard++;
        end
        chk({tag, "_drained"}, 32'(exp_l.size()), 32'd0);
        repeat (4) tick();
        chk({tag, "_idle_l"}, 32'(out_l.data_valid), 32'd0);
        chk({tag, "_idle_m"}, 32'(out_m.data_valid), 32'd0);
        chk({tag, "_in_req_cnt"}, 32'(in_req_cnt), 32'(loads_exp));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_l"}, 32'({in_l.req, out_l.data_valid, out_l.data, out_l.last_bit_in_byte}), 32'd0);
        chk({tag, "_m"}, 32'({in_m.req, out_m.data_valid, out_m.data, out_m.last_bit_in_byte}), 32'd0);
    endtask

    initial begin
        drive_src();
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (4) tick();
        chk_all_zero("post_reset_idle");

        push(8'hA5, 3'd0);
        run_stream("byte_a5");

        push(8'h01, 3'd0);
        push(8'hFF, 3'd0);
        run_stream("b2b_01_ff");

        push(8'h00, 3'd0);
        push(8'h3C, 3'd5);
        run_stream("partial_3c");

        push(8'h80, 3'd0);
        push(8'h05, 3'd3);
        run_stream("msb_80_05");

        push(8'h01, 3'd1);
        push(8'hFE, 3'd1);
        run_stream("single_bit");

        push(8'hC3, 3'd0);
        tb_out_req = 1'b1;
        run_stream("idle_req");

        push(8'hF0, 3'd0);
        tick();
        repeat (8) tick();
        repeat (3) consume_bit("rst_pre");
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        exp_l.delete();
        exp_m.delete();
        src_q.delete();
        drive_src();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk_all_zero("reset_release_idle");
        push(8'h96, 3'd0);
        run_stream("restart_96");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
